// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 8 data + odd parity + stop, ACK check.
// Optional feature macro PS2_TX_RETRY_EN: retry the latched byte up to RETRY_MAX times on timeout or NACK.
//
// state        | meaning
// ST_IDLE      | bus released; accepts a byte once tx_ready is back up
// ST_INHIBIT   | clock pulled low for INHIBIT_CYCLES
// ST_RTS       | start bit on data, clock released, waiting for first device fall
// ST_DATA      | shifting data bits, parity, then releasing data for stop
// ST_ACK       | sampling the device ACK on the 11th fall
// ST_WAIT_IDLE | waiting for both lines high before reporting done
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int RETRY_MAX      = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
`ifdef PS2_TX_RETRY_EN
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    state_t        state;
    logic [7:0]    tx_byte;
    logic          parity;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmo_cnt;
`ifdef PS2_TX_RETRY_EN
    logic [RW-1:0] retry_cnt;
`endif

    logic       clk_meta, clk_sync, data_meta, data_sync;
    logic [2:0] clk_hist;
    logic       fall, active, bus_idle, tmo_hit, nack_hit;

    // Idle-high reset values keep a reset release from looking like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_hist  <= 3'b111;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
            clk_hist  <= {clk_hist[1:0], clk_sync};
        end
    end

    assign fall     = (clk_hist[2:1] == 2'b10);
    assign active   = (state == ST_RTS) || (state == ST_DATA) ||
                      (state == ST_ACK) || (state == ST_WAIT_IDLE);
    assign bus_idle = clk_sync && data_sync;
    // A fall or a completed idle wait in the same cycle wins over the timeout.
    assign tmo_hit  = active && !fall && (tmo_cnt == '0) &&
                      !((state == ST_WAIT_IDLE) && bus_idle);
    assign nack_hit = (state == ST_ACK) && fall && data_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx_byte     <= 8'h00;
            parity      <= 1'b0;
            bit_cnt     <= 4'd0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;

            if (active) begin
                if (fall) begin
                    tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
                end else if (tmo_cnt != '0) begin
                    tmo_cnt <= tmo_cnt - TW'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    // tx_ready comes back one cycle after done/err, so that cycle never accepts.
                    if (!tx_ready) begin
                        tx_ready <= 1'b1;
                    end else if (tx_valid) begin
                        tx_byte    <= tx_data;
                        parity     <= ~^tx_data;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        inh_cnt    <= IW'(INHIBIT_CYCLES - 1);
                        state      <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        retry_cnt  <= '0;
`endif
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt == '0) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        tmo_cnt     <= TW'(TIMEOUT_CYCLES - 1);
                        state       <= ST_RTS;
                    end else begin
                        inh_cnt <= inh_cnt - IW'(1);
                    end
                end
                ST_RTS: begin
                    if (fall) begin
                        ps2_data_oe <= ~tx_byte[0];
                        bit_cnt     <= 4'd1;
                        state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        if (bit_cnt < 4'd8) begin
                            ps2_data_oe <= ~tx_byte[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            ps2_data_oe <= ~parity;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state       <= ST_ACK;
                        end
                        if (bit_cnt != 4'd10) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (fall && !data_sync) begin
                        state <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (bus_idle) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (tmo_hit || nack_hit) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                if (retry_cnt < RW'(RETRY_MAX)) begin
                    retry_cnt  <= retry_cnt + RW'(1);
                    ps2_clk_oe <= 1'b1;
                    inh_cnt    <= IW'(INHIBIT_CYCLES - 1);
                    state      <= ST_INHIBIT;
                end else begin
                    err      <= 1'b1;
                    err_code <= nack_hit ? 2'b10 : 2'b01;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
`else
                err      <= 1'b1;
                err_code <= nack_hit ? 2'b10 : 2'b01;
                busy     <= 1'b0;
                state    <= ST_IDLE;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while
// a monitor pops expected done/err responses and checks pulse shape and tx_ready recovery.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 200;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, err;
    logic [1:0] err_code;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .busy(busy), .done(done), .err(err), .err_code(err_code),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    int checks = 0;
    int failures = 0;
    int inhibit_phases = 0;
    logic [2:0]  exp_resp[$];   // {is_err, err_code}
    logic [10:0] exp_frame[$];  // bit i = value the device samples on rise i (bit 0 = start)

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic par);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now("ready_wait");
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("clk_oe_after_accept", ps2_clk_oe, 1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("end_wait");
        @(negedge clk);
    endtask

    // Device side: waits for RTS, issues 11 clocks (half-period 10), samples on rises.
    task automatic dev_run(input bit ack, input int abort_at, output bit ok, output logic [10:0] frame);
        int n;
        ok = 1'b0;
        frame = '0;
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            fail_now("rts_wait");
            return;
        end
        repeat (10) @(negedge clk);
        frame[0] = ps2_data_in;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) begin
                dev_data = 1'b0;
                repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            if (k == abort_at) return;
            dev_clk = 1'b1;
            if (k <= 10) frame[k] = ps2_data_in;
            repeat (10) @(negedge clk);
        end
        dev_data = 1'b1;
        ok = 1'b1;
    endtask

    task automatic dev_check(input bit ack);
        bit ok;
        logic [10:0] fr;
        logic [10:0] ef;
        dev_run(ack, 0, ok, fr);
        if (ok) begin
            ef = (exp_frame.size() != 0) ? exp_frame.pop_front() : 11'h7ff;
            check("frame", fr, ef);
        end
    endtask

    // Response monitor: pops one expectation per done/err pulse.
    initial begin : resp_mon
        logic prev_end;
        logic [2:0] r;
        prev_end = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_end = 1'b0;
                continue;
            end
            if (prev_end) begin
                check("ready_after_end", tx_ready, 1);
                check("pulse_width", {30'd0, done, err}, 0);
            end
            if (done || err) begin
                check("ready_in_end_cycle", tx_ready, 0);
                if (exp_resp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got done=%0b err=%0b expected none", done, err);
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_err", err, r[2]);
                    check("resp_done", done, !r[2]);
                    check("err_code", err_code, r[1:0]);
                    if (err) check("oe_at_err", {ps2_clk_oe, ps2_data_oe}, 0);
                end
            end
            prev_end = done || err;
        end
    end

    initial begin : inh_mon
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) run = 0;
            else if (ps2_clk_oe) run++;
            else if (run != 0) begin
                check("inhibit_len", run, INH);
                inhibit_phases++;
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit ok;
        logic [10:0] fr;
        int n, t;

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_done_err", {done, err}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", tx_ready, 1);

        // 0xED with ACK: parity 1
        exp_resp.push_back(3'b000);
        exp_frame.push_back(frame_of(8'hED, 1'b1));
        send(8'hED);
        dev_check(1'b1);
        wait_ready();

        // 0xF4 with ACK: parity 0; tx_valid held through the done cycle must be ignored
        exp_resp.push_back(3'b000);
        exp_frame.push_back(frame_of(8'hF4, 1'b0));
        send(8'hF4);
        dev_check(1'b1);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h12;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        if (n >= 200) fail_now("done_wait");
        repeat (5) @(negedge clk);
        check("held_valid_busy", busy, 0);
        check("held_valid_clk_oe", ps2_clk_oe, 0);
        check("held_valid_ready", tx_ready, 1);

        // 0x55 NACK: parity 1
        exp_resp.push_back(3'b110);
        for (int a = 0; a < ATTEMPTS; a++) exp_frame.push_back(frame_of(8'h55, 1'b1));
        send(8'h55);
        for (int a = 0; a < ATTEMPTS; a++) dev_check(1'b0);
        wait_ready();

        // 0xFF, device silent: err 200 cycles after the last RTS entry
        exp_resp.push_back(3'b101);
        send(8'hFF);
        t = 0;
        n = 0;
        while (n < 5000) begin
            @(negedge clk);
            n++;
            if (err) break;
            t = ps2_clk_oe ? 0 : t + 1;
        end
        if (n >= 5000) fail_now("timeout_wait");
        else check("timeout_latency", t, TMO);
        wait_ready();

        // Reset after fall #5
        send(8'h3C);
        dev_run(1'b1, 5, ok, fr);
        rst = 1'b1;
        #1;
        check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("midrst_ready", tx_ready, 1);
        check("midrst_busy", busy, 0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 0xA7 after reset: parity 0
        exp_resp.push_back(3'b000);
        exp_frame.push_back(frame_of(8'hA7, 1'b0));
        send(8'hA7);
        dev_check(1'b1);
        wait_ready();

`ifdef PS2_TX_RETRY_EN
        // NACK then ACK: two inhibit phases, done and no err
        n = inhibit_phases;
        exp_resp.push_back(3'b000);
        exp_frame.push_back(frame_of(8'hF4, 1'b0));
        exp_frame.push_back(frame_of(8'hF4, 1'b0));
        send(8'hF4);
        dev_check(1'b0);
        dev_check(1'b1);
        wait_ready();
        check("retry_inhibit_phases", inhibit_phases - n, 2);
`endif

        repeat (5) @(negedge clk);
        check("resp_queue_empty", exp_resp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
